// File: rtl/pe_adder_tree_acc.sv
// pe_adder_tree_acc
//   Pipelined signed reduction tree followed by a multi-beat channel
//   accumulator and a saturating output register. Each valid beat sums N_IN
//   fixed-point operands. Beats tagged first..last fold into one group result,
//   which is clamped to OUT_W bits. The result is presented with a one-cycle
//   valid pulse and status flags.
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   en           global enable; low freezes every register
//   in_valid     beat qualifier
//   in_first     beat opens a new group (only meaningful with in_valid)
//   in_last      beat closes the group (only meaningful with in_valid)
//   in_flat      N_IN operands, operand k at [k*IN_W +: IN_W]
//   out_valid    one enabled-cycle pulse per completed group
//   out_data     saturated group sum
//   out_sat      out_data was clamped
//   out_err      group ran past MAX_BEATS beats (accumulator may have wrapped)
//
// Latency: beat accepted at edge t -> accumulator at t+D -> output at t+D+1.
module pe_adder_tree_acc #(
   parameter int N_IN      = 49,
   parameter int IN_W      = 32,
   parameter int FRAC      = 16,
   parameter int OUT_W     = 32,
   parameter int MAX_BEATS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [N_IN*IN_W-1:0] in_flat,
   output logic                 out_valid,
   output logic [OUT_W-1:0]     out_data,
   output logic                 out_sat,
   output logic                 out_err
);

   // Number of elements in tree layer l (layer 0 = the operands).
   function automatic int lvl_cnt(input int l);
      return (N_IN + (1 << l) - 1) >> l;
   endfunction

   // Index of the first element of layer l in the flattened layer space.
   function automatic int lvl_base(input int l);
      int b;
      b = 0;
      for (int j = 0; j < l; j++) b += lvl_cnt(j);
      return b;
   endfunction

   localparam int D      = $clog2(N_IN);
   localparam int SUM_W  = IN_W + D;
   localparam int ACC_W  = SUM_W + $clog2(MAX_BEATS);
   localparam int ALL_N  = lvl_base(D + 1);    // operands + all tree nodes
   localparam int NODE_N = ALL_N - N_IN;       // registered tree nodes only
   // Counter holds 0..MAX_BEATS+1 and sticks at MAX_BEATS+1, so an
   // over-long group can never wrap back below the limit.
   localparam int CNT_W  = $clog2(MAX_BEATS + 2);
   localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] SAT_LO = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // Elaboration-time parameter sanity.
   if (N_IN < 2) begin : g_bad_n_in
      $error("pe_adder_tree_acc: N_IN must be >= 2");
   end
   if (MAX_BEATS < 1) begin : g_bad_max_beats
      $error("pe_adder_tree_acc: MAX_BEATS must be >= 1");
   end
   if (FRAC < 0 || FRAC >= IN_W || FRAC >= OUT_W) begin : g_bad_frac
      $error("pe_adder_tree_acc: FRAC must lie inside IN_W and OUT_W");
   end

   // ------------------------------------------------------------------
   // Reduction tree
   // ------------------------------------------------------------------
   logic signed [SUM_W-1:0] all_v  [ALL_N];
   logic signed [SUM_W-1:0] node_d [NODE_N];
   logic signed [SUM_W-1:0] node_q [NODE_N];

   // Operands are sign-extended to SUM_W up front, so no tree add overflows.
   for (genvar k = 0; k < N_IN; k++) begin : g_op
      assign all_v[k] = SUM_W'($signed(in_flat[k*IN_W +: IN_W]));
   end
   for (genvar k = 0; k < NODE_N; k++) begin : g_nq
      assign all_v[N_IN+k] = node_q[k];
   end

   for (genvar l = 1; l <= D; l++) begin : g_lvl
      for (genvar k = 0; k < lvl_cnt(l); k++) begin : g_node
         localparam int SRC = lvl_base(l - 1) + 2 * k;
         localparam int DST = lvl_base(l) - N_IN + k;
         if (2 * k + 1 < lvl_cnt(l - 1)) begin : g_pair
            assign node_d[DST] = all_v[SRC] + all_v[SRC+1];
         end else begin : g_pass
            // Odd element at the end of the layer: carried through unchanged.
            assign node_d[DST] = all_v[SRC];
         end
      end
   end

   // Sideband shift registers, one bit per tree layer.
   logic [D-1:0] vld_d, vld_q;
   logic [D-1:0] fst_d, fst_q;
   logic [D-1:0] lst_d, lst_q;

   always_comb begin
      vld_d    = '0;
      fst_d    = '0;
      lst_d    = '0;
      vld_d[0] = in_valid;
      fst_d[0] = in_valid & in_first;
      lst_d[0] = in_valid & in_last;
      for (int i = 1; i < D; i++) begin
         vld_d[i] = vld_q[i-1];
         fst_d[i] = fst_q[i-1];
         lst_d[i] = lst_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NODE_N; i++) node_q[i] <= '0;
         vld_q <= '0;
         fst_q <= '0;
         lst_q <= '0;
      end else if (en) begin
         node_q <= node_d;
         vld_q  <= vld_d;
         fst_q  <= fst_d;
         lst_q  <= lst_d;
      end
   end

   logic                    tree_vld, tree_fst, tree_lst;
   logic signed [SUM_W-1:0] tree_sum;

   assign tree_vld = vld_q[D-1];
   assign tree_fst = fst_q[D-1];
   assign tree_lst = lst_q[D-1];
   assign tree_sum = node_q[NODE_N-1];

   // ------------------------------------------------------------------
   // Accumulator
   // ------------------------------------------------------------------
   // done_q marks that the previous accumulator update closed a group: the
   // output stage reads acc_q this cycle, and the group state is treated as
   // zero for whatever comes next (a beat starts fresh, an idle cycle clears).
   logic signed [ACC_W-1:0] acc_d, acc_q, acc_base;
   logic [CNT_W-1:0]        cnt_d, cnt_q, cnt_base;
   logic                    err_d, err_q, err_base;
   logic                    done_d, done_q;
   logic                    restart;

   always_comb begin
      restart  = tree_fst | done_q;
      acc_base = restart ? '0 : acc_q;
      cnt_base = restart ? '0 : cnt_q;
      err_base = restart ? 1'b0 : err_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      done_d   = 1'b0;
      if (tree_vld) begin
         acc_d  = acc_base + ACC_W'(tree_sum);
         cnt_d  = (cnt_base == CNT_SAT) ? cnt_base : cnt_base + CNT_W'(1);
         err_d  = err_base | (cnt_d > CNT_MAX);
         done_d = tree_lst;
      end else if (done_q) begin
         acc_d = '0;
         cnt_d = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (en) begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // Saturating output stage
   // ------------------------------------------------------------------
   logic signed [EXT_W-1:0] acc_ext;
   logic                    sat_hi, sat_lo;
   logic [OUT_W-1:0]        sat_data;

   // One guard bit beyond max(ACC_W, OUT_W) keeps the signed compares exact
   // whichever of the two widths is larger.
   assign acc_ext = EXT_W'(acc_q);
   assign sat_hi  = acc_ext > SAT_HI;
   assign sat_lo  = acc_ext < SAT_LO;

   always_comb begin
      sat_data = OUT_W'(acc_ext);
      if (sat_hi)      sat_data = {1'b0, {(OUT_W-1){1'b1}}};
      else if (sat_lo) sat_data = {1'b1, {(OUT_W-1){1'b0}}};
   end

   logic             out_valid_q;
   logic [OUT_W-1:0] out_data_q;
   logic             out_sat_q;
   logic             out_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (en) begin
         out_valid_q <= done_q;
         if (done_q) begin
            out_data_q <= sat_data;
            out_sat_q  <= sat_hi | sat_lo;
            out_err_q  <= err_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_pe_adder_tree_acc.sv
// tb_pe_adder_tree_acc
//   Two instances share one stimulus stream: the default build
//   (MAX_BEATS=64) and a MAX_BEATS=4 build. A behavioural group-sum model
//   pushes the expected result for every closing beat; the monitor pops
//   it when out_valid rises and compares data, flags and latency.
module tb_pe_adder_tree_acc;

   localparam int N  = 49;
   localparam int W  = 32;
   localparam int OW = 32;
   localparam int D  = 6;     // clog2(49)

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en  = 1'b1;
   logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
   logic [N*W-1:0] in_flat = '0;

   logic          a_valid, a_sat, a_err;
   logic [OW-1:0] a_data;
   logic          b_valid, b_sat, b_err;
   logic [OW-1:0] b_data;

   always #5 clk = ~clk;

   pe_adder_tree_acc #(.N_IN(N), .IN_W(W), .FRAC(16), .OUT_W(OW), .MAX_BEATS(64)) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_flat(in_flat),
      .out_valid(a_valid), .out_data(a_data), .out_sat(a_sat), .out_err(a_err)
   );

   pe_adder_tree_acc #(.N_IN(N), .IN_W(W), .FRAC(16), .OUT_W(OW), .MAX_BEATS(4)) u_dut_m4 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_flat(in_flat),
      .out_valid(b_valid), .out_data(b_data), .out_sat(b_sat), .out_err(b_err)
   );

   typedef struct {
      logic [31:0] data;
      logic        sat;
      logic        err;
      logic        err4;
      int          eacc;   // enabled-edge index at acceptance of the last beat
      int          aacc;   // absolute edge index at acceptance
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   longint      m_acc = 0;
   int          m_cnt = 0;
   int          n_chk = 0, n_pass = 0;
   int          ecyc = 0, acyc = 0;
   int          last_lat_abs = 0;
   string       cur = "init";
   logic [31:0] ops [N];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Group-sum reference, applied to each beat the DUT accepts.
   task automatic model_beat();
      longint s;
      exp_t   e;
      s = 0;
      for (int k = 0; k < N; k++) s += longint'($signed(in_flat[k*W +: W]));
      if (in_first) begin
         m_acc = 0;
         m_cnt = 0;
      end
      m_acc += s;
      m_cnt++;
      if (in_last) begin
         if (m_acc > 64'sd2147483647) begin
            e.data = 32'h7FFF_FFFF; e.sat = 1'b1;
         end else if (m_acc < -64'sd2147483648) begin
            e.data = 32'h8000_0000; e.sat = 1'b1;
         end else begin
            e.data = m_acc[31:0];   e.sat = 1'b0;
         end
         e.err  = (m_cnt > 64);
         e.err4 = (m_cnt > 4);
         e.eacc = ecyc;
         e.aacc = acyc;
         e.tag  = cur;
         sb_q.push_back(e);
         m_acc = 0;
         m_cnt = 0;
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (a_valid || b_valid) begin
         if (sb_q.size() == 0) begin
            chk({cur, ":spurious_valid"}, {62'd0, a_valid, b_valid}, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk({e.tag, ":valid"},    a_valid, 1);
            chk({e.tag, ":valid_m4"}, b_valid, 1);
            chk({e.tag, ":data"},     a_data,  e.data);
            chk({e.tag, ":sat"},      a_sat,   e.sat);
            chk({e.tag, ":err"},      a_err,   e.err);
            chk({e.tag, ":data_m4"},  b_data,  e.data);
            chk({e.tag, ":sat_m4"},   b_sat,   e.sat);
            chk({e.tag, ":err_m4"},   b_err,   e.err4);
            chk({e.tag, ":latency"},  ecyc - e.eacc, D + 1);
            last_lat_abs = acyc - e.aacc;
         end
      end else if (sb_q.size() != 0 && (ecyc - sb_q[0].eacc) >= D + 1) begin
         e = sb_q.pop_front();
         chk({e.tag, ":missing_valid"}, 0, 1);
      end
   endtask

   // One clock: record acceptance at the edge, sample outputs 1 time unit later.
   task automatic tick();
      bit enabled;
      @(posedge clk);
      acyc++;
      enabled = en && !rst;
      if (enabled) begin
         ecyc++;
         if (in_valid) model_beat();
      end
      #1;
      if (enabled) monitor();
   endtask

   task automatic set_all(input logic [31:0] v);
      for (int k = 0; k < N; k++) ops[k] = v;
   endtask

   task automatic beat(input bit f, input bit l);
      for (int k = 0; k < N; k++) in_flat[k*W +: W] = ops[k];
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, ":valid"},   a_valid, 0);
      chk({tag, ":data"},    a_data,  0);
      chk({tag, ":sat"},     a_sat,   0);
      chk({tag, ":err"},     a_err,   0);
      chk({tag, ":valid_m4"}, b_valid, 0);
      chk({tag, ":data_m4"},  b_data,  0);
   endtask

   initial begin
      int nb;
      // Asynchronous reset, checked before any clock edge.
      #1 rst = 1'b1;
      #2 chk_zero_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      cur = "single_1p0";
      set_all(32'h0001_0000);
      beat(1, 1);
      idle(10);

      cur = "signed";
      for (int k = 0; k < N; k++) ops[k] = (k % 2 == 0) ? 32'h0002_8000 : 32'hFFFD_8000;
      beat(1, 1);
      set_all(32'hFFFF_0000);
      beat(1, 1);
      idle(10);

      // Three-beat group, then immediately a single-beat group.
      cur = "b2b";
      set_all(32'h0001_0000);
      beat(1, 0); beat(0, 0); beat(0, 1);
      set_all(32'h0002_0000);
      beat(1, 1);
      idle(10);

      cur = "sat_pos";
      set_all(32'h7FFF_FFFF);
      beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 1);
      cur = "sat_neg";
      set_all(32'h8000_0000);
      beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 1);
      idle(10);

      // Five beats overflow the MAX_BEATS=4 build's limit; the next group is clean.
      cur = "overlong";
      set_all(32'h0001_0000);
      beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 0); beat(0, 1);
      cur = "after_overlong";
      beat(1, 1);
      idle(10);

      // A beat with first=0 right after a last starts from zero; invalid
      // beats carrying first/last flags must not disturb the group.
      cur = "restart";
      set_all(32'h0001_0000);
      beat(1, 1);
      set_all(32'h0002_0000);
      beat(0, 1);
      cur = "bubbles";
      set_all(32'h0003_0000);
      beat(1, 0);
      in_valid = 1'b0; in_first = 1'b1; in_last = 1'b1;
      tick(); tick();
      beat(0, 1);
      idle(10);

      // Enable low for 3 cycles while the last beat is inside the tree.
      cur = "stall";
      set_all(32'h0001_0000);
      beat(1, 0); beat(0, 1);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      idle(10);
      chk("stall:abs_latency", last_lat_abs, D + 1 + 3);

      // Reset while a completed group is still in flight: it must vanish.
      cur = "mid_reset";
      set_all(32'h0005_0000);
      beat(1, 0); beat(0, 1);
      idle(2);
      #2 rst = 1'b1;
      #1 chk_zero_outputs("mid_reset");
      sb_q.delete();
      m_acc = 0;
      m_cnt = 0;
      tick(); tick();
      rst = 1'b0;
      idle(10);
      cur = "post_reset";
      set_all(32'h0001_0000);
      beat(0, 1);
      idle(10);

      cur = "random";
      for (int g = 0; g < 20; g++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < N; k++)
               ops[k] = 32'($urandom_range(0, 33554431)) - 32'h0100_0000;
            beat(b == 0, b == nb - 1);
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               in_first = 1'($urandom_range(0, 1));
               in_last  = 1'($urandom_range(0, 1));
               tick();
            end
         end
      end
      idle(12);

      chk("end:scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
